addsub_accum_ctrl: RTL and testbench
====================================

Name: addsub_accum_ctrl

Overview:
- Sequencer that feeds an operand stream through the team's registered n-bit add/subtract datapath and returns a single signed sum per job.
- Sits between an upstream valid/ready operand source and the datapath instance. Drives the datapath's A, B, Sel and AddSub inputs every cycle, and reads back its Z and Overflow outputs.
- Sustains one operand per cycle. Returns the result, plus a sticky overflow flag, on a valid/ready result port.

Parameters:
- n, 5, operand/result width, two's complement.

Ports:
- Clock  in  1  single clock; rising edge.
- Reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  operand beat valid.
- op_ready  out  1  controller accepts a beat this cycle.
- op_data  in  n  signed operand.
- op_sub  in  1  subtract this operand; ignored on the first beat of a job.
- op_last  in  1  final operand of the job.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_data  out  n  job result, modulo 2^n.
- res_overflow  out  1  signed overflow at any step of the job (sticky).
- dp_A  out  n  datapath A operand.
- dp_B  out  n  datapath B operand.
- dp_Sel  out  1  datapath feedback select (1 = use Z in place of A).
- dp_AddSub  out  1  datapath subtract.
- dp_Z  in  n  datapath registered result.
- dp_Overflow  in  1  datapath registered overflow.

Behaviour:
- Datapath contract:
  - The datapath registers A, B, Sel and AddSub on every edge.
  - An op registered at edge e appears on dp_Z and dp_Overflow after edge e+1.
  - With Sel=1, the op uses the dp_Z value present in the cycle after registration, so back-to-back chained ops are legal.
- Bubble op:
  - Driven on every cycle with no issue: dp_Sel=1, dp_B=0, dp_AddSub=0, dp_A=0.
  - Holds dp_Z unchanged and never raises overflow.
- States: IDLE, PAIR, ACCUM, DRAIN, DONE.
- op_ready=1 in IDLE, PAIR and ACCUM; op_ready=0 in DRAIN and DONE.
- IDLE:
  - On accept, capture op_data into hold register h and clear the sticky flag.
  - If op_last=1: issue A=h, B=0, Sel=0, add, then go to DRAIN.
  - Otherwise go to PAIR.
  - The single-operand issue happens on the cycle after capture.
- PAIR:
  - On accept, issue combinationally in the same cycle: A=h, B=op_data, Sel=0, AddSub=op_sub.
  - If op_last=1 go to DRAIN, else go to ACCUM.
  - Drive bubbles while waiting.
- ACCUM:
  - On accept, issue Sel=1, B=op_data, AddSub=op_sub.
  - If op_last=1 go to DRAIN.
  - Drive bubbles while waiting.
- Pipe-valid shift p1/p2 tracks real ops in flight.
  - On each edge where p2=1, set sticky |= dp_Overflow.
- DRAIN:
  - Wait until the last issued op's result is on dp_Z: the last issue is at edge e, and dp_Z is sampled at edge e+2.
  - At that edge, res_data <= dp_Z and res_overflow <= sticky | dp_Overflow.
  - Go to DONE.
- Latency: the last beat accepted at edge e gives res_valid=1 after edge e+2.
- DONE:
  - res_valid=1; res_data and res_overflow are held stable.
  - On res_valid & res_ready, go to IDLE and drop res_valid.
- Arithmetic is modulo 2^n.
  - Overflow is any signed overflow of an intermediate or final step; wrap-around is not saturated.
- Reset (async, any state):
  - State to IDLE; h, sticky, p1 and p2 cleared.
  - res_valid=0, res_data=0, res_overflow=0.
  - dp outputs set to the bubble values.
  - The datapath's own reset is driven from the same source (inverted at top level).
  - A job in progress is discarded; no partial result is emitted.
- Simultaneous events:
  - The handshake in DONE and a new op_valid on the same cycle: the op is not accepted, because op_ready=0; it is accepted in IDLE on the next cycle.
  - op_valid low mid-job is legal, with any number of bubbles.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, PAIR, ACCUM, DRAIN, DONE);
  - the default width n=5;
  - the datapath latency constant DP_LAT=2.
- No sub-module. The FSM, the issue mux and the pipe-valid tracking are one module.
- The datapath remains a separate sibling instance, wired at the enclosing top level.

Test Plan:
- n=5. Beats 3, then +4 (last), back-to-back → res_data=7, res_overflow=0, res_valid exactly 2 cycles after the last accept.
- Beats 10, 3 with op_sub=1, then 6 (last) → res_data=13, res_overflow=0.
- Beats 12, then 7 (last) → res_data=5'b10011, res_overflow=1. A following job of 1, then 1 (last) → res_data=2, res_overflow=0 (sticky cleared).
- Single beat 5'b11011 (-5) with op_last=1 → res_data=5'b11011, res_overflow=0.
- Beats 2, 2, 2 (last) with 2 idle cycles between beats and res_ready low for 3 cycles → res_data=6 and held stable; op_ready=0 throughout DONE.
- Reset pulsed while in ACCUM → res_valid, res_data and op state clear immediately, and no result is emitted. A subsequent job of 1, then -1 (op_sub on 1) → res_data=0.

Source files
------------

// File: rtl/addsub_accum_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_accum_ctrl_pkg
// Description : Shared widths, latency and state encoding for the accumulator
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package addsub_accum_ctrl_pkg;

  localparam int DEF_N   = 5;
  localparam int DP_LAT  = 2;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    PAIR  = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/addsub_accum_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : addsub_accum_ctrl_if
// Description : Operand, result and datapath-side signals of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface addsub_accum_ctrl_if
  import addsub_accum_ctrl_pkg::*;
#(
  parameter int n = DEF_N
) ();

  logic         op_valid;
  logic         op_ready;
  logic [n-1:0] op_data;
  logic         op_sub;
  logic         op_last;
  logic         res_valid;
  logic         res_ready;
  logic [n-1:0] res_data;
  logic         res_overflow;
  logic [n-1:0] dp_A;
  logic [n-1:0] dp_B;
  logic         dp_Sel;
  logic         dp_AddSub;
  logic [n-1:0] dp_Z;
  logic         dp_Overflow;

  // Environment side: operand source, result sink and the datapath instance.
  modport master (
    output op_valid, op_data, op_sub, op_last, res_ready, dp_Z, dp_Overflow,
    input  op_ready, res_valid, res_data, res_overflow,
           dp_A, dp_B, dp_Sel, dp_AddSub
  );

  modport slave (
    input  op_valid, op_data, op_sub, op_last, res_ready, dp_Z, dp_Overflow,
    output op_ready, res_valid, res_data, res_overflow,
           dp_A, dp_B, dp_Sel, dp_AddSub
  );

endinterface
`default_nettype wire

// File: rtl/addsub_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : addsub_accum_ctrl
// Description : Feeds an operand stream through a registered add/sub datapath
//               and returns one signed sum plus sticky overflow per job.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_accum_ctrl
  import addsub_accum_ctrl_pkg::*;
#(
  parameter int n = DEF_N
) (
  input  wire logic         Clock,
  input  wire logic         Reset,
  addsub_accum_ctrl_if.slave bus
);

  localparam logic [DP_LAT-1:0] C_PV_TAIL = {1'b1, {(DP_LAT-1){1'b0}}};

  state_t            r_state;
  state_t            w_state_next;
  logic [n-1:0]      r_h;
  logic              r_sticky;
  logic              r_single;
  logic [DP_LAT-1:0] r_pv;
  logic              r_res_valid;
  logic [n-1:0]      r_res_data;
  logic              r_res_ovf;

  logic              w_op_ready;
  logic              w_accept;
  logic              w_issue;
  logic              w_finish;
  logic [n-1:0]      w_dp_a;
  logic [n-1:0]      w_dp_b;
  logic              w_dp_sel;
  logic              w_dp_sub;

  assign w_accept = bus.op_valid & w_op_ready;

  // Issue mux defaults to the bubble op, which re-adds zero to dp_Z.
  always_comb begin
    w_state_next = r_state;
    w_op_ready   = 1'b0;
    w_issue      = 1'b0;
    w_finish     = 1'b0;
    w_dp_a       = '0;
    w_dp_b       = '0;
    w_dp_sel     = 1'b1;
    w_dp_sub     = 1'b0;
    case (r_state)
      IDLE: begin
        w_op_ready = 1'b1;
        if (bus.op_valid)
          w_state_next = bus.op_last ? DRAIN : PAIR;
      end
      PAIR: begin
        w_op_ready = 1'b1;
        if (bus.op_valid) begin
          w_issue      = 1'b1;
          w_dp_a       = r_h;
          w_dp_b       = bus.op_data;
          w_dp_sel     = 1'b0;
          w_dp_sub     = bus.op_sub;
          w_state_next = bus.op_last ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        w_op_ready = 1'b1;
        if (bus.op_valid) begin
          w_issue  = 1'b1;
          w_dp_b   = bus.op_data;
          w_dp_sub = bus.op_sub;
          if (bus.op_last)
            w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (r_single) begin
          w_issue  = 1'b1;
          w_dp_a   = r_h;
          w_dp_sel = 1'b0;
        end else if (r_pv == C_PV_TAIL) begin
          // Only the final op is left in the pipe and its result is on dp_Z.
          w_finish     = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready)
          w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_h         <= '0;
      r_sticky    <= 1'b0;
      r_single    <= 1'b0;
      r_pv        <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_ovf   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_single <= (r_state == IDLE) && w_accept && bus.op_last;
      r_pv     <= {r_pv[DP_LAT-2:0], w_issue};
      if ((r_state == IDLE) && w_accept) begin
        r_h      <= bus.op_data;
        r_sticky <= 1'b0;
      end else if (r_pv[DP_LAT-1]) begin
        r_sticky <= r_sticky | bus.dp_Overflow;
      end
      if (w_finish) begin
        r_res_valid <= 1'b1;
        r_res_data  <= bus.dp_Z;
        r_res_ovf   <= r_sticky | bus.dp_Overflow;
      end else if ((r_state == DONE) && bus.res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign bus.op_ready     = w_op_ready;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_data     = r_res_data;
  assign bus.res_overflow = r_res_ovf;
  assign bus.dp_A         = w_dp_a;
  assign bus.dp_B         = w_dp_b;
  assign bus.dp_Sel       = w_dp_sel;
  assign bus.dp_AddSub    = w_dp_sub;

endmodule
`default_nettype wire

// File: tb/tb_addsub_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_accum_ctrl
// Description : Directed self-checking bench with a behavioural registered
//               add/sub datapath wired to the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_accum_ctrl;

  localparam int N = 5;

  logic Clock;
  logic Reset;
  int   n_checks;
  int   n_fail;

  addsub_accum_ctrl_if #(.n(N)) bus ();

  addsub_accum_ctrl #(.n(N)) u_dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Datapath: operands registered on every edge, result one edge later.
  logic [N-1:0] m_a, m_b, m_z;
  logic         m_sel, m_sub, m_ov;

  function automatic logic [N:0] dp_calc(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic sub);
    logic [N-1:0] z;
    logic         ov;
    z  = sub ? (a - b) : (a + b);
    ov = sub ? ((a[N-1] != b[N-1]) && (z[N-1] != a[N-1]))
             : ((a[N-1] == b[N-1]) && (z[N-1] != a[N-1]));
    return {ov, z};
  endfunction

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_a   <= '0;
      m_b   <= '0;
      m_sel <= 1'b1;
      m_sub <= 1'b0;
      m_z   <= '0;
      m_ov  <= 1'b0;
    end else begin
      m_a          <= bus.dp_A;
      m_b          <= bus.dp_B;
      m_sel        <= bus.dp_Sel;
      m_sub        <= bus.dp_AddSub;
      {m_ov, m_z}  <= dp_calc(m_sel ? m_z : m_a, m_b, m_sub);
    end
  end

  assign bus.dp_Z        = m_z;
  assign bus.dp_Overflow = m_ov;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called and returns at #1 after a rising edge; returns after the accept edge.
  task automatic beat(input logic [N-1:0] d, input logic sub, input logic last);
    logic rdy;
    bit   done;
    done         = 1'b0;
    bus.op_valid = 1'b1;
    bus.op_data  = d;
    bus.op_sub   = sub;
    bus.op_last  = last;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge Clock);
      rdy = bus.op_ready;
      @(posedge Clock);
      #1;
      done = rdy;
    end
    if (!done) check("beat_accept", 32'd0, 32'd1);
    bus.op_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input logic [N-1:0] exp_d, input logic exp_o);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge Clock);
      seen = bus.res_valid;
    end
    check({tag, "_valid"}, 32'(seen), 32'd1);
    check({tag, "_data"}, 32'(bus.res_data), 32'(exp_d));
    check({tag, "_ovf"}, 32'(bus.res_overflow), 32'(exp_o));
    bus.res_ready = 1'b1;
    @(posedge Clock);
    #1;
    bus.res_ready = 1'b0;
    check({tag, "_drop"}, 32'(bus.res_valid), 32'd0);
  endtask

  task automatic idle_cycles(input int cnt);
    repeat (cnt) @(posedge Clock);
    #1;
  endtask

  initial begin
    bit seen;
    bit stray;
    n_checks      = 0;
    n_fail        = 0;
    Reset         = 1'b1;
    bus.op_valid  = 1'b0;
    bus.op_data   = '0;
    bus.op_sub    = 1'b0;
    bus.op_last   = 1'b0;
    bus.res_ready = 1'b0;
    idle_cycles(2);

    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_res_ovf", 32'(bus.res_overflow), 32'd0);
    check("rst_op_ready", 32'(bus.op_ready), 32'd1);
    check("rst_dp_bubble", {bus.dp_A, bus.dp_B, bus.dp_Sel, bus.dp_AddSub},
          {5'd0, 5'd0, 1'b1, 1'b0});
    Reset = 1'b0;
    idle_cycles(1);

    // 3 + 4, back to back; result exactly two edges after the last accept
    beat(5'd3, 1'b0, 1'b0);
    beat(5'd4, 1'b0, 1'b1);
    check("t1_lat0", 32'(bus.res_valid), 32'd0);
    idle_cycles(1);
    check("t1_lat1", 32'(bus.res_valid), 32'd0);
    idle_cycles(1);
    check("t1_lat2", 32'(bus.res_valid), 32'd1);
    collect("t1", 5'd7, 1'b0);

    // 10 - 3 + 6
    beat(5'd10, 1'b0, 1'b0);
    beat(5'd3, 1'b1, 1'b0);
    beat(5'd6, 1'b0, 1'b1);
    collect("t2", 5'd13, 1'b0);

    // 12 + 7 wraps negative, then sticky flag must clear on the next job
    beat(5'd12, 1'b0, 1'b0);
    beat(5'd7, 1'b0, 1'b1);
    collect("t3", 5'b10011, 1'b1);
    beat(5'd1, 1'b0, 1'b0);
    beat(5'd1, 1'b0, 1'b1);
    collect("t3b", 5'd2, 1'b0);

    // single beat -5
    beat(5'b11011, 1'b0, 1'b1);
    collect("t4", 5'b11011, 1'b0);

    // 2 + 2 + 2 with gaps; consumer stalls while a new op waits in DONE
    beat(5'd2, 1'b0, 1'b0);
    idle_cycles(2);
    beat(5'd2, 1'b0, 1'b0);
    idle_cycles(2);
    beat(5'd2, 1'b0, 1'b1);
    bus.op_valid = 1'b1;
    bus.op_data  = 5'd9;
    bus.op_sub   = 1'b0;
    bus.op_last  = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge Clock);
      seen = bus.res_valid;
    end
    check("t5_valid", 32'(seen), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      check("t5_hold_valid", 32'(bus.res_valid), 32'd1);
      check("t5_hold_data", 32'(bus.res_data), 32'd6);
      check("t5_done_ready", 32'(bus.op_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge Clock);
    #1;
    bus.res_ready = 1'b0;
    check("t5_drop", 32'(bus.res_valid), 32'd0);
    check("t5_idle_ready", 32'(bus.op_ready), 32'd1);
    idle_cycles(1);
    bus.op_valid = 1'b0;
    collect("t5b", 5'd9, 1'b0);

    // reset mid-job in ACCUM with a beat pending
    beat(5'd4, 1'b0, 1'b0);
    beat(5'd5, 1'b0, 1'b0);
    bus.op_valid = 1'b1;
    bus.op_data  = 5'd7;
    bus.op_last  = 1'b0;
    Reset        = 1'b1;
    #1;
    check("t6_rst_valid", 32'(bus.res_valid), 32'd0);
    check("t6_rst_data", 32'(bus.res_data), 32'd0);
    check("t6_rst_dp", {bus.dp_A, bus.dp_B, bus.dp_Sel, bus.dp_AddSub},
          {5'd0, 5'd0, 1'b1, 1'b0});
    bus.op_valid = 1'b0;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    stray = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clock);
      stray = stray | bus.res_valid;
    end
    check("t6_no_result", 32'(stray), 32'd0);
    @(posedge Clock);
    #1;
    beat(5'd1, 1'b0, 1'b0);
    beat(5'd1, 1'b1, 1'b1);
    collect("t6", 5'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
